// File: rtl/score_ram_ctrl.sv
// ---------------------------------------------------------------------------
// score_ram_ctrl
// Per-player level / high-score store sitting between the game controller and
// a single-port synchronous RAM. After reset every score slot is written with
// zero. A game start loads the player's stored best level as the starting
// level. Each level completion bumps the level (saturating) and writes it back
// only when it beats the stored best. Game over reloads the best level for
// the final display.
//
// Ports
//   clk           in   1       system clock
//   reset         in   1       asynchronous, active-low reset
//   user_id       in   UID_W   current player ID
//   game_state    in   8       state code from the game controller
//   data_in       in   DATA_W  RAM read data
//   r_w           out  1       RAM strobe: 1 = write, 0 = read
//   address_out   out  ADDR_W  RAM address
//   data_out      out  DATA_W  RAM write data
//   cur_level     out  DATA_W  current / start / final level
//   busy          out  1       high while clearing or servicing an event
//   unknown_user  out  1       one-cycle pulse: event for an ID not in table
// ---------------------------------------------------------------------------
module score_ram_ctrl #(
    parameter int                         NUM_USERS   = 4,
    parameter int                         UID_W       = 4,
    parameter int                         DATA_W      = 8,
    parameter int                         ADDR_W      = 8,
    parameter int                         BASE_ADDR   = 0,
    parameter logic [NUM_USERS*UID_W-1:0] USER_IDS    = {4'b0100, 4'b1101, 4'b0011, 4'b1100},
    parameter int                         RD_LAT      = 2,
    parameter int                         LVL_MAX     = 255,
    parameter logic [7:0]                 ST_START    = 8'h10,
    parameter logic [7:0]                 ST_LVL_DONE = 8'h20,
    parameter logic [7:0]                 ST_OVER     = 8'h30
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [UID_W-1:0]  user_id,
    input  logic [7:0]        game_state,
    input  logic [DATA_W-1:0] data_in,
    output logic              r_w,
    output logic [ADDR_W-1:0] address_out,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] cur_level,
    output logic              busy,
    output logic              unknown_user
);

    localparam int SLOT_W = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1;
    localparam int CNT_W  = $clog2(NUM_USERS + 1);
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [DATA_W:0]   LVL_MAX_X = (DATA_W + 1)'(LVL_MAX);

    localparam logic [1:0] S_CLEAR   = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_WRITE   = 2'd3;

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_clr_cnt;
    logic [LAT_W-1:0]  r_lat_cnt;
    logic [7:0]        r_gs_q;
    logic              r_pend_vld;
    logic [7:0]        r_pend_code;
    logic [UID_W-1:0]  r_pend_uid;
    logic              r_lvl;
    logic              r_w_q;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_cur;
    logic              r_unknown;

    logic              w_is_code;
    logic              w_evt;
    logic              w_svc_vld;
    logic              w_defer;
    logic [7:0]        w_svc_code;
    logic [UID_W-1:0]  w_svc_uid;
    logic              w_match;
    logic [SLOT_W-1:0] w_idx;
    logic [DATA_W-1:0] w_nxt;

    // Level increment done one bit wider so the carry cannot wrap before the
    // clamp to LVL_MAX.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        logic [DATA_W:0] w_sum;
        w_sum = {1'b0, v} + (DATA_W + 1)'(1);
        if (w_sum > LVL_MAX_X)
            return LVL_MAX_X[DATA_W-1:0];
        return w_sum[DATA_W-1:0];
    endfunction

    // An event is an edge into one of the three recognised codes; holding a
    // code produces nothing further because gs_q catches up after one cycle.
    assign w_is_code = (game_state == ST_START) || (game_state == ST_LVL_DONE) ||
                       (game_state == ST_OVER);
    assign w_evt     = w_is_code && (game_state != r_gs_q);

    // A parked event has priority in IDLE; a fresh event arriving in that same
    // cycle (or any cycle while busy) is parked, replacing whatever was there.
    assign w_svc_vld  = (r_state == S_IDLE) && (r_pend_vld || w_evt);
    assign w_svc_code = r_pend_vld ? r_pend_code : game_state;
    assign w_svc_uid  = r_pend_vld ? r_pend_uid  : user_id;
    assign w_defer    = w_evt && ((r_state != S_IDLE) || r_pend_vld);

    // Descending scan so the lowest matching slot is the one left standing.
    always_comb begin
        w_match = 1'b0;
        w_idx   = '0;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if (USER_IDS[i*UID_W +: UID_W] == w_svc_uid) begin
                w_match = 1'b1;
                w_idx   = SLOT_W'(i);
            end
        end
    end

    assign w_nxt = sat_inc(r_cur);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_CLEAR;
            r_clr_cnt   <= '0;
            r_lat_cnt   <= '0;
            r_gs_q      <= '0;
            r_pend_vld  <= 1'b0;
            r_pend_code <= '0;
            r_pend_uid  <= '0;
            r_lvl       <= 1'b0;
            r_w_q       <= 1'b0;
            r_addr      <= BASE;
            r_wdata     <= '0;
            r_cur       <= '0;
            r_unknown   <= 1'b0;
        end else begin
            r_gs_q    <= game_state;
            r_unknown <= 1'b0;

            if (w_defer) begin
                r_pend_vld  <= 1'b1;
                r_pend_code <= game_state;
                r_pend_uid  <= user_id;
            end else if (w_svc_vld && r_pend_vld) begin
                r_pend_vld  <= 1'b0;
            end

            case (r_state)
                S_CLEAR: begin
                    // One zero write per slot; the extra pass drops the strobe.
                    if (r_clr_cnt == CNT_W'(NUM_USERS)) begin
                        r_w_q   <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_w_q     <= 1'b1;
                        r_wdata   <= '0;
                        r_addr    <= BASE + ADDR_W'(r_clr_cnt);
                        r_clr_cnt <= r_clr_cnt + CNT_W'(1);
                    end
                end

                S_IDLE: begin
                    r_w_q <= 1'b0;
                    if (w_svc_vld) begin
                        if (w_match) begin
                            r_addr    <= BASE + ADDR_W'(w_idx);
                            r_lvl     <= (w_svc_code == ST_LVL_DONE);
                            r_lat_cnt <= '0;
                            r_state   <= S_RD_WAIT;
                        end else begin
                            r_unknown <= 1'b1;
                        end
                    end
                end

                S_RD_WAIT: begin
                    if (r_lat_cnt == LAT_W'(RD_LAT - 1)) begin
                        if (r_lvl) begin
                            r_cur <= w_nxt;
                            // address_out still holds the slot for the write-back.
                            if (w_nxt > data_in) begin
                                r_wdata <= w_nxt;
                                r_w_q   <= 1'b1;
                                r_state <= S_WRITE;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_cur   <= data_in;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt + LAT_W'(1);
                    end
                end

                default: begin  // S_WRITE
                    r_w_q   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign r_w          = r_w_q;
    assign address_out  = r_addr;
    assign data_out     = r_wdata;
    assign cur_level    = r_cur;
    assign busy         = (r_state != S_IDLE);
    assign unknown_user = r_unknown;

endmodule

// File: tb/tb_score_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_score_ram_ctrl
// Bench for score_ram_ctrl: a RAM model with a two-cycle read path, a write /
// unknown-user monitor, and a reference model that tracks the best level per
// player, the displayed level, expected writes and expected unknown pulses.
// ---------------------------------------------------------------------------
module tb_score_ram_ctrl;

    localparam logic [7:0] ST_START    = 8'h10;
    localparam logic [7:0] ST_LVL_DONE = 8'h20;
    localparam logic [7:0] ST_OVER     = 8'h30;
    localparam int         LVL_MAX     = 255;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] user_id;
    logic [7:0] game_state;
    logic [7:0] data_in;
    logic       r_w;
    logic [7:0] address_out;
    logic [7:0] data_out;
    logic [7:0] cur_level;
    logic       busy;
    logic       unknown_user;

    always #10 clk = ~clk;

    score_ram_ctrl #(
        .NUM_USERS(4), .UID_W(4), .DATA_W(8), .ADDR_W(8), .BASE_ADDR(0),
        .USER_IDS({4'b0100, 4'b1101, 4'b0011, 4'b1100}), .RD_LAT(2),
        .LVL_MAX(255), .ST_START(ST_START), .ST_LVL_DONE(ST_LVL_DONE), .ST_OVER(ST_OVER)
    ) dut (
        .clk(clk), .reset(reset), .user_id(user_id), .game_state(game_state),
        .data_in(data_in), .r_w(r_w), .address_out(address_out), .data_out(data_out),
        .cur_level(cur_level), .busy(busy), .unknown_user(unknown_user)
    );

    // RAM: address registered once inside, data registered once more -> the
    // value for an address presented after edge N is sampled at edge N+2.
    logic [7:0] mem [256];
    logic [7:0] rd_q;
    logic       bd_we = 1'b0;
    logic [7:0] bd_addr = '0;
    logic [7:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_we)    mem[bd_addr]     <= bd_data;
        else if (r_w) mem[address_out] <= data_out;
        rd_q <= mem[address_out];
    end
    assign data_in = rd_q;

    typedef struct { int addr; int data; int cyc; } wr_t;

    int  cyc = 0;
    wr_t act_wq[$];
    int  act_unk = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reset === 1'b1 && r_w === 1'b1)
            act_wq.push_back('{int'(address_out), int'(data_out), cyc});
        if (unknown_user === 1'b1) act_unk++;
    end

    // Reference model
    logic [3:0] ids [4] = '{4'b1100, 4'b0011, 4'b1101, 4'b0100};
    int  best [4];
    int  exp_cur = 0;
    int  exp_unk = 0;
    wr_t exp_wq[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic int find_slot(input logic [3:0] uid);
        for (int i = 0; i < 4; i++) if (ids[i] == uid) return i;
        return -1;
    endfunction

    function automatic string fmt_wq(input wr_t q[$]);
        string s;
        s = $sformatf("%0d write(s)", q.size());
        foreach (q[i]) s = {s, $sformatf(" %0d:%0d", q[i].addr, q[i].data)};
        return s;
    endfunction

    task automatic model_apply(input logic [7:0] code, input logic [3:0] uid);
        int s;
        int nxt;
        s = find_slot(uid);
        if (s < 0) begin
            exp_unk++;
            return;
        end
        if (code == ST_LVL_DONE) begin
            nxt = (exp_cur + 1 > LVL_MAX) ? LVL_MAX : exp_cur + 1;
            exp_cur = nxt;
            if (nxt > best[s]) begin
                best[s] = nxt;
                exp_wq.push_back('{s, nxt, 0});
            end
        end else begin
            exp_cur = best[s];
        end
    endtask

    task automatic bd_write(input int addr, input int data);
        bd_addr = 8'(addr);
        bd_data = 8'(data);
        bd_we   = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
        if (addr < 4) best[addr] = data;
    endtask

    task automatic drive_event(input logic [7:0] code, input logic [3:0] uid);
        if (game_state == code) begin
            @(posedge clk);
            #1 game_state = 8'h00;
        end
        @(posedge clk);
        #1;
        game_state = code;
        user_id    = uid;
        model_apply(code, uid);
    endtask

    task automatic settle();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bit done;
        reset = 1'b0;
        game_state = 8'h00;
        user_id = 4'h0;
        for (int i = 0; i < 4; i++) bd_write(i, 8'hA5 + i);
        #3;
        n_checks++; if (busy !== 1'b1) $display("FAIL rst_busy: got %b need 1", busy); else n_pass++;
        n_checks++; if (r_w !== 1'b0) $display("FAIL rst_r_w: got %b need 0", r_w); else n_pass++;
        n_checks++; if (address_out !== 8'd0) $display("FAIL rst_addr: got %0d need 0", address_out); else n_pass++;
        n_checks++; if (data_out !== 8'd0) $display("FAIL rst_data: got %0d need 0", data_out); else n_pass++;
        n_checks++; if (cur_level !== 8'd0) $display("FAIL rst_level: got %0d need 0", cur_level); else n_pass++;
        n_checks++; if (unknown_user !== 1'b0) $display("FAIL rst_unknown: got %b need 0", unknown_user); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b1;
        act_wq.delete();
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1;
        end
        n_checks++; if (!done) $display("FAIL clear_timeout: busy still %b after 20 cycles, need 0", busy); else n_pass++;
        for (int i = 0; i < 4; i++) best[i] = 0;
        exp_cur = 0;
        done = (act_wq.size() == 4);
        if (done) foreach (act_wq[i])
            if (act_wq[i].addr != i || act_wq[i].data != 0 || act_wq[i].cyc != act_wq[0].cyc + i) done = 0;
        n_checks++; if (!done) $display("FAIL clear_writes: got %s, need 4 consecutive 0:0 1:0 2:0 3:0", fmt_wq(act_wq)); else n_pass++;
        n_checks++; if (r_w !== 1'b0) $display("FAIL clear_r_w_idle: got %b need 0", r_w); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (mem[i] !== 8'd0) $display("FAIL clear_mem%0d: got %0d need 0", i, mem[i]); else n_pass++;
        end
        act_wq.delete();
    endtask

    task automatic test_start_latency();
        int prev;
        bd_write(1, 5);
        prev = exp_cur;
        drive_event(ST_START, 4'b0011);
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (address_out !== 8'd1 || r_w !== 1'b0) $display("FAIL start_read: got addr %0d r_w %b need addr 1 r_w 0", address_out, r_w); else n_pass++;
        @(negedge clk);
        n_checks++; if (cur_level !== 8'(prev)) $display("FAIL start_early: got %0d need %0d", cur_level, prev); else n_pass++;
        @(negedge clk);
        n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL start_level: got %0d need %0d", cur_level, exp_cur); else n_pass++;
        settle();
        n_checks++; if (act_wq.size() != 0) $display("FAIL start_nowrite: got %s need 0 write(s)", fmt_wq(act_wq)); else n_pass++;
        act_wq.delete();
        exp_wq.delete();
    endtask

    task automatic test_level_done_hold();
        bit ok;
        drive_event(ST_LVL_DONE, 4'b0011);
        repeat (10) @(posedge clk);
        settle();
        n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL hold_level: got %0d need %0d", cur_level, exp_cur); else n_pass++;
        ok = (act_wq.size() == exp_wq.size());
        if (ok) foreach (exp_wq[i]) if (act_wq[i].addr != exp_wq[i].addr || act_wq[i].data != exp_wq[i].data) ok = 0;
        n_checks++; if (!ok) $display("FAIL hold_writes: got %s need %s", fmt_wq(act_wq), fmt_wq(exp_wq)); else n_pass++;
        act_wq.delete();
        exp_wq.delete();
        drive_event(ST_START, 4'b0011);
        settle();
        drive_event(ST_LVL_DONE, 4'b0011);
        settle();
        n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL replay_level: got %0d need %0d", cur_level, exp_cur); else n_pass++;
        ok = (act_wq.size() == exp_wq.size());
        if (ok) foreach (exp_wq[i]) if (act_wq[i].addr != exp_wq[i].addr || act_wq[i].data != exp_wq[i].data) ok = 0;
        n_checks++; if (!ok) $display("FAIL replay_writes: got %s need %s", fmt_wq(act_wq), fmt_wq(exp_wq)); else n_pass++;
        act_wq.delete();
        exp_wq.delete();
    endtask

    task automatic test_no_new_best();
        bd_write(1, 3);
        drive_event(ST_START, 4'b0011);
        settle();
        bd_write(1, 9);
        drive_event(ST_LVL_DONE, 4'b0011);
        settle();
        n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL nobest_level: got %0d need %0d", cur_level, exp_cur); else n_pass++;
        n_checks++; if (act_wq.size() != exp_wq.size()) $display("FAIL nobest_writes: got %s need %s", fmt_wq(act_wq), fmt_wq(exp_wq)); else n_pass++;
        act_wq.delete();
        exp_wq.delete();
    endtask

    task automatic test_saturation();
        bit ok;
        bd_write(1, 255);
        drive_event(ST_START, 4'b0011);
        settle();
        drive_event(ST_LVL_DONE, 4'b0011);
        settle();
        n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL sat255_level: got %0d need %0d", cur_level, exp_cur); else n_pass++;
        n_checks++; if (act_wq.size() != 0) $display("FAIL sat255_nowrite: got %s need 0 write(s)", fmt_wq(act_wq)); else n_pass++;
        act_wq.delete();
        exp_wq.delete();
        bd_write(2, 254);
        drive_event(ST_START, 4'b1101);
        settle();
        drive_event(ST_LVL_DONE, 4'b1101);
        settle();
        drive_event(ST_LVL_DONE, 4'b1101);
        settle();
        n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL sat254_level: got %0d need %0d", cur_level, exp_cur); else n_pass++;
        ok = (act_wq.size() == exp_wq.size());
        if (ok) foreach (exp_wq[i]) if (act_wq[i].addr != exp_wq[i].addr || act_wq[i].data != exp_wq[i].data) ok = 0;
        n_checks++; if (!ok) $display("FAIL sat254_writes: got %s need %s", fmt_wq(act_wq), fmt_wq(exp_wq)); else n_pass++;
        act_wq.delete();
        exp_wq.delete();
    endtask

    task automatic test_unknown();
        drive_event(ST_LVL_DONE, 4'b1111);
        settle();
        n_checks++; if (act_unk != exp_unk) $display("FAIL unknown_pulse: got %0d high cycle(s) need %0d", act_unk, exp_unk); else n_pass++;
        n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL unknown_level: got %0d need %0d", cur_level, exp_cur); else n_pass++;
        n_checks++; if (act_wq.size() != 0) $display("FAIL unknown_nowrite: got %s need 0 write(s)", fmt_wq(act_wq)); else n_pass++;
        act_wq.delete();
        exp_wq.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        bd_write(1, 40);
        drive_event(ST_START, 4'b0011);
        settle();
        drive_event(ST_LVL_DONE, 4'b0011);
        drive_event(ST_OVER, 4'b0011);
        #2;
        n_checks++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b need 1", busy); else n_pass++;
        settle();
        n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL b2b_over_level: got %0d need %0d", cur_level, exp_cur); else n_pass++;
        ok = (act_wq.size() == exp_wq.size());
        if (ok) foreach (exp_wq[i]) if (act_wq[i].addr != exp_wq[i].addr || act_wq[i].data != exp_wq[i].data) ok = 0;
        n_checks++; if (!ok) $display("FAIL b2b_writes: got %s need %s", fmt_wq(act_wq), fmt_wq(exp_wq)); else n_pass++;
        act_wq.delete();
        exp_wq.delete();
        // The game-over code is replaced in the pending slot by the restart.
        bd_write(1, 7);
        drive_event(ST_LVL_DONE, 4'b0011);
        @(posedge clk);
        #1 game_state = ST_OVER;
        drive_event(ST_START, 4'b0011);
        settle();
        n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL overwrite_level: got %0d need %0d", cur_level, exp_cur); else n_pass++;
        n_checks++; if (act_wq.size() != exp_wq.size()) $display("FAIL overwrite_writes: got %s need %s", fmt_wq(act_wq), fmt_wq(exp_wq)); else n_pass++;
        act_wq.delete();
        exp_wq.delete();
    endtask

    task automatic test_random();
        bit   ok;
        int   bad = 0;
        int   pick;
        logic [7:0] code;
        logic [3:0] uid;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 5) == 0)
                bd_write($urandom_range(0, 3), $urandom_range(200, 255));
            pick = $urandom_range(0, 2);
            code = (pick == 0) ? ST_START : (pick == 1) ? ST_LVL_DONE : ST_OVER;
            pick = $urandom_range(0, 4);
            uid  = (pick == 4) ? 4'b1111 : ids[pick];
            drive_event(code, uid);
            settle();
            n_checks++; if (cur_level !== 8'(exp_cur)) $display("FAIL rand%0d_level: code %h uid %b got %0d need %0d", it, code, uid, cur_level, exp_cur); else n_pass++;
            ok = (act_wq.size() == exp_wq.size());
            if (ok) foreach (exp_wq[i]) if (act_wq[i].addr != exp_wq[i].addr || act_wq[i].data != exp_wq[i].data) ok = 0;
            n_checks++; if (!ok) $display("FAIL rand%0d_writes: got %s need %s", it, fmt_wq(act_wq), fmt_wq(exp_wq)); else n_pass++;
            act_wq.delete();
            exp_wq.delete();
        end
        n_checks++; if (act_unk != exp_unk) $display("FAIL rand_unknown: got %0d pulse cycle(s) need %0d", act_unk, exp_unk); else n_pass++;
        for (int i = 0; i < 4; i++) if (int'(mem[i]) != best[i]) bad++;
        n_checks++; if (bad != 0) $display("FAIL rand_mem: got %0d %0d %0d %0d need %0d %0d %0d %0d", mem[0], mem[1], mem[2], mem[3], best[0], best[1], best[2], best[3]); else n_pass++;
    endtask

    task automatic test_reset_mid_write();
        bit done;
        bit ok;
        bd_write(0, 10);
        drive_event(ST_START, 4'b1100);
        settle();
        drive_event(ST_LVL_DONE, 4'b1100);
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (r_w === 1'b1) done = 1;
        end
        n_checks++; if (!done) $display("FAIL midwr_seen: r_w got %b within 10 cycles need 1", r_w); else n_pass++;
        #1 reset = 1'b0;
        game_state = 8'h00;
        #1;
        n_checks++; if (r_w !== 1'b0 || address_out !== 8'd0 || busy !== 1'b1 || cur_level !== 8'd0)
            $display("FAIL midwr_async: got r_w %b addr %0d busy %b level %0d need 0 0 1 0", r_w, address_out, busy, cur_level);
        else n_pass++;
        act_wq.delete();
        exp_wq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        done = 0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (busy === 1'b0) done = 1;
        end
        n_checks++; if (!done) $display("FAIL midwr_timeout: busy still %b after 20 cycles, need 0", busy); else n_pass++;
        ok = (act_wq.size() == 4);
        if (ok) foreach (act_wq[i]) if (act_wq[i].addr != i || act_wq[i].data != 0) ok = 0;
        n_checks++; if (!ok) $display("FAIL midwr_clear: got %s need 4 write(s) 0:0 1:0 2:0 3:0", fmt_wq(act_wq)); else n_pass++;
        n_checks++; if (mem[0] !== 8'd0) $display("FAIL midwr_mem0: got %0d need 0", mem[0]); else n_pass++;
        for (int i = 0; i < 4; i++) best[i] = 0;
        exp_cur = 0;
        act_wq.delete();
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_level_done_hold();
        test_no_new_best();
        test_saturation();
        test_unknown();
        test_back_to_back();
        test_random();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
